// File: rtl/refresh_scheduler.sv
// -----------------------------------------------------------------------------
// refresh_scheduler
//
// Sequences an all-bank refresh. When the refresh manager asks for one, normal
// traffic is blocked, in-flight bursts drain, open rows are closed with PREA,
// tRP is waited out, REF is issued, and the block waits for the manager's
// completion and for its flags to clear before normal traffic is allowed again.
//
// Optional feature (compile-time macro REFRESH_POSTPONE_EN):
//   When defined, a refresh request that arrives while normal traffic is
//   pending is deferred (DEFER state) for up to POSTPONE_MAX cycles, or until
//   the traffic goes away. When undefined, DEFER, its counter and the
//   POSTPONE_MAX parameter do not exist.
//
// Parameters
//   TRP           precharge-to-refresh delay in sys_clk cycles (1..255)
//   POSTPONE_MAX  max deferral in cycles (1..65535), REFRESH_POSTPONE_EN only
//
// Ports
//   sys_clk         in   single clock, rising edge
//   sys_rst_n       in   asynchronous active-low reset
//   refresh_needed  in   refresh request from the refresh manager
//   refresh_done    in   refresh completion from the refresh manager
//   refresh         out  one-cycle start pulse to the refresh manager
//   bank_group      out  refresh target bank group, always 2'b00 (all-bank)
//   bank            out  refresh target bank, always 2'b00 (all-bank)
//   bank_open       in   open-row bitmap, bit index {bank_group,bank}
//   burst_busy      in   data burst in flight
//   cmd_req         in   normal traffic pending
//   cmd_allow       out  normal ACT/RD/WR permitted
//   pre_all         out  one-cycle PREA command pulse to the PHY
//   ref_cmd         out  one-cycle REF command pulse to the PHY
//   ref_active      out  high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module refresh_scheduler #(
    parameter int TRP = 15
`ifdef REFRESH_POSTPONE_EN
    ,
    parameter int POSTPONE_MAX = 1024
`endif
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        refresh_needed,
    input  logic        refresh_done,
    output logic        refresh,
    output logic [1:0]  bank_group,
    output logic [1:0]  bank,
    input  logic [15:0] bank_open,
    input  logic        burst_busy,
    input  logic        cmd_req,
    output logic        cmd_allow,
    output logic        pre_all,
    output logic        ref_cmd,
    output logic        ref_active
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
`ifdef REFRESH_POSTPONE_EN
        ST_DEFER     = 3'd1,
`endif
        ST_DRAIN     = 3'd2,
        ST_PRECHARGE = 3'd3,
        ST_WAIT_TRP  = 3'd4,
        ST_REFRESH   = 3'd5,
        ST_WAIT_DONE = 3'd6,
        ST_RELEASE   = 3'd7
    } state_t;

    // WAIT_TRP is left when the counter holds TRP-1, giving exactly TRP cycles.
    localparam logic [7:0] TRP_LAST = 8'(TRP - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  trp_cnt_reg;
    logic [7:0]  trp_cnt_next;

    // Outputs are registered: their next values are decoded from state_next,
    // so each output changes on the same edge the state it belongs to is
    // entered and never glitches.
    logic        pre_all_reg;
    logic        pre_all_next;
    logic        ref_pulse_reg;
    logic        ref_pulse_next;
    logic        cmd_allow_reg;
    logic        cmd_allow_next;
    logic        ref_active_reg;
    logic        ref_active_next;

`ifdef REFRESH_POSTPONE_EN
    // The counter counts the DEFER cycle being spent, so holding it at
    // POSTPONE_MAX-1 means POSTPONE_MAX cycles have been used up.
    localparam logic [15:0] POSTPONE_LAST = 16'(POSTPONE_MAX - 1);

    logic [15:0] postpone_cnt_reg;
    logic [15:0] postpone_cnt_next;
`else
    // Without deferral there is nothing to do with pending traffic.
    logic        unused_cmd_req;
    assign unused_cmd_req = cmd_req;
`endif

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg   <= ST_IDLE;
            trp_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            trp_cnt_reg <= trp_cnt_next;
        end
    end

`ifdef REFRESH_POSTPONE_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            postpone_cnt_reg <= '0;
        end else begin
            postpone_cnt_reg <= postpone_cnt_next;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        trp_cnt_next = '0;
`ifdef REFRESH_POSTPONE_EN
        postpone_cnt_next = '0;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (refresh_needed) begin
`ifdef REFRESH_POSTPONE_EN
                    state_next = cmd_req ? ST_DEFER : ST_DRAIN;
`else
                    state_next = ST_DRAIN;
`endif
                end
            end

`ifdef REFRESH_POSTPONE_EN
            ST_DEFER: begin
                // The counter falls back to zero on exit via the default above.
                if (!cmd_req || (postpone_cnt_reg == POSTPONE_LAST)) begin
                    state_next = ST_DRAIN;
                end else begin
                    postpone_cnt_next = postpone_cnt_reg + 16'd1;
                end
            end
`endif

            // Once here the refresh always runs to completion, even if
            // refresh_needed drops.
            ST_DRAIN: begin
                if (!burst_busy) begin
                    state_next = (|bank_open) ? ST_PRECHARGE : ST_REFRESH;
                end
            end

            ST_PRECHARGE: begin
                state_next = ST_WAIT_TRP;
            end

            // bank_open is deliberately not looked at here: PREA already
            // closed everything, so late updates of the bitmap are irrelevant.
            ST_WAIT_TRP: begin
                if (trp_cnt_reg == TRP_LAST) begin
                    state_next = ST_REFRESH;
                end else begin
                    trp_cnt_next = trp_cnt_reg + 8'd1;
                end
            end

            ST_REFRESH: begin
                state_next = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                if (refresh_done) begin
                    state_next = ST_RELEASE;
                end
            end

            // The manager clears refresh_needed/refresh_done one cycle late;
            // waiting for both to be low keeps that stale request from
            // starting a second refresh.
            ST_RELEASE: begin
                if (!refresh_needed && !refresh_done) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (from the state about to be entered)
    // -------------------------------------------------------------------------
    always_comb begin
        pre_all_next    = (state_next == ST_PRECHARGE);
        ref_pulse_next  = (state_next == ST_REFRESH);
        ref_active_next = (state_next != ST_IDLE);
`ifdef REFRESH_POSTPONE_EN
        cmd_allow_next  = (state_next == ST_IDLE) || (state_next == ST_DEFER);
`else
        cmd_allow_next  = (state_next == ST_IDLE);
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_all_reg    <= 1'b0;
            ref_pulse_reg  <= 1'b0;
            cmd_allow_reg  <= 1'b1;
            ref_active_reg <= 1'b0;
        end else begin
            pre_all_reg    <= pre_all_next;
            ref_pulse_reg  <= ref_pulse_next;
            cmd_allow_reg  <= cmd_allow_next;
            ref_active_reg <= ref_active_next;
        end
    end

    // PRECHARGE and REFRESH are single-cycle states always followed by a
    // different state, so these pulses can never be two cycles long.
    assign pre_all    = pre_all_reg;
    assign refresh    = ref_pulse_reg;
    assign ref_cmd    = ref_pulse_reg;
    assign cmd_allow  = cmd_allow_reg;
    assign ref_active = ref_active_reg;

    // Only all-bank refresh is supported.
    assign bank_group = 2'b00;
    assign bank       = 2'b00;

endmodule

// File: tb/tb_refresh_scheduler.sv
// -----------------------------------------------------------------------------
// tb_refresh_scheduler
//
// Scoreboard bench for refresh_scheduler. Stimulus pushes the expected command
// pulses (kind and cycle number) into a queue; a monitor on the falling edge
// pops one entry every time the DUT drives pre_all/ref_cmd/refresh and
// compares. Level outputs (cmd_allow, ref_active) are checked inline.
// Build with REFRESH_POSTPONE_EN defined to exercise the deferral path.
// -----------------------------------------------------------------------------
module tb_refresh_scheduler;

    localparam int TRP = 4;
`ifdef REFRESH_POSTPONE_EN
    localparam int PMAX = 8;
`endif

    // {pre_all, ref_cmd, refresh}
    localparam logic [2:0] K_PRE = 3'b100;
    localparam logic [2:0] K_REF = 3'b011;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        refresh_needed = 1'b0;
    logic        refresh_done = 1'b0;
    logic        refresh;
    logic [1:0]  bank_group;
    logic [1:0]  bank;
    logic [15:0] bank_open = 16'h0000;
    logic        burst_busy = 1'b0;
    logic        cmd_req = 1'b0;
    logic        cmd_allow;
    logic        pre_all;
    logic        ref_cmd;
    logic        ref_active;

    refresh_scheduler #(
        .TRP(TRP)
`ifdef REFRESH_POSTPONE_EN
        ,
        .POSTPONE_MAX(PMAX)
`endif
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .refresh_needed (refresh_needed),
        .refresh_done   (refresh_done),
        .refresh        (refresh),
        .bank_group     (bank_group),
        .bank           (bank),
        .bank_open      (bank_open),
        .burst_busy     (burst_busy),
        .cmd_req        (cmd_req),
        .cmd_allow      (cmd_allow),
        .pre_all        (pre_all),
        .ref_cmd        (ref_cmd),
        .ref_active     (ref_active)
    );

    always #5 sys_clk = ~sys_clk;

    // Cycle k is the interval after the k-th rising edge.
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] kind;
        int         at;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    task automatic expect_pulse(input logic [2:0] kind, input int at, input string name);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Currently in WAIT_DONE: manager completes and clears its request together.
    task automatic handshake(input string name);
        refresh_done   = 1'b1;
        refresh_needed = 1'b0;
        tick();
        check({name, "_release_active"}, 32'(ref_active), 32'd1);
        refresh_done = 1'b0;
        tick();
        check({name, "_idle_allow"}, 32'(cmd_allow), 32'd1);
        check({name, "_idle_inactive"}, 32'(ref_active), 32'd0);
    endtask

    // ---------------------------------------------------------------- monitor
    logic [2:0] seen;
    exp_t       got_e;
    always @(negedge sys_clk) begin
        seen = {pre_all, ref_cmd, refresh};
        if (seen !== 3'b000) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got pulses %b at cycle %0d, required none", seen, cyc);
            end else begin
                got_e = exp_q.pop_front();
                if (seen !== got_e.kind || cyc != got_e.at || bank_group !== 2'b00 || bank !== 2'b00) begin
                    n_fail++;
                    $display("FAIL %s: got pulses %b at cycle %0d target %b/%b, required %b at cycle %0d target 00/00",
                             got_e.name, seen, cyc, bank_group, bank, got_e.kind, got_e.at);
                end else begin
                    $display("ok   %s: pulses %b at cycle %0d", got_e.name, seen, cyc);
                end
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    int c;
    initial begin
        // Reset state
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_refresh",    32'(refresh),    32'd0);
        check("rst_pre_all",    32'(pre_all),    32'd0);
        check("rst_ref_cmd",    32'(ref_cmd),    32'd0);
        check("rst_ref_active", 32'(ref_active), 32'd0);
        check("rst_cmd_allow",  32'(cmd_allow),  32'd1);
        check("rst_bank_group", 32'(bank_group), 32'd0);
        check("rst_bank",       32'(bank),       32'd0);
        sys_rst_n = 1'b1;
        tick();
        tick();

        // A: one open bank, no burst. Request at t -> PREA at t+2, REF at t+3+TRP.
        // Then manager holds refresh_needed one cycle after refresh_done.
        tick();
        c = cyc;
        refresh_needed = 1'b1;
        bank_open      = 16'h0001;
        expect_pulse(K_PRE, c + 2, "a_pre_all");
        expect_pulse(K_REF, c + 3 + TRP, "a_refresh");
        tick();                                   // DRAIN
        check("a_drain_allow", 32'(cmd_allow), 32'd0);
        check("a_drain_active", 32'(ref_active), 32'd1);
        tick();                                   // PRECHARGE
        tick();                                   // WAIT_TRP, bitmap change ignored
        bank_open = 16'h0000;
        repeat (TRP) tick();                      // REFRESH
        tick();                                   // WAIT_DONE
        check("a_wait_done_active", 32'(ref_active), 32'd1);
        refresh_done = 1'b1;
        tick();                                   // RELEASE
        refresh_done = 1'b0;
        tick();                                   // still RELEASE: needed=1
        check("a_release_hold_active", 32'(ref_active), 32'd1);
        check("a_release_hold_allow",  32'(cmd_allow),  32'd0);
        refresh_needed = 1'b0;
        tick();                                   // IDLE
        check("a_idle_allow",  32'(cmd_allow),  32'd1);
        check("a_idle_active", 32'(ref_active), 32'd0);
        repeat (3) tick();

        // B: no open bank -> no PREA, REF two cycles after the request.
        tick();
        c = cyc;
        refresh_needed = 1'b1;
        bank_open      = 16'h0000;
        expect_pulse(K_REF, c + 2, "b_refresh");
        tick();                                   // DRAIN
        tick();                                   // REFRESH
        tick();                                   // WAIT_DONE
        handshake("b");
        repeat (2) tick();

        // C: burst busy for 7 cycles of DRAIN; PREA the cycle after it falls.
        tick();
        c = cyc;
        refresh_needed = 1'b1;
        bank_open      = 16'h8000;
        burst_busy     = 1'b1;
        expect_pulse(K_PRE, c + 9, "c_pre_all");
        expect_pulse(K_REF, c + 10 + TRP, "c_refresh");
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("c_drain_allow", 32'(cmd_allow), 32'd0);
        end
        tick();                                   // c+8, busy drops now
        burst_busy = 1'b0;
        check("c_drain_allow_last", 32'(cmd_allow), 32'd0);
        tick();                                   // PRECHARGE
        check("c_pre_allow", 32'(cmd_allow), 32'd0);
        repeat (TRP + 1) tick();                  // REFRESH
        tick();                                   // WAIT_DONE
        handshake("c");
        repeat (2) tick();

        // D: reset during WAIT_TRP abandons the sequence; next request restarts.
        tick();
        c = cyc;
        refresh_needed = 1'b1;
        bank_open      = 16'h0010;
        expect_pulse(K_PRE, c + 2, "d_pre_all");
        repeat (4) tick();                        // WAIT_TRP
        check("d_wait_trp_active", 32'(ref_active), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("d_rst_pulses", 32'({pre_all, ref_cmd, refresh}), 32'd0);
        check("d_rst_allow",  32'(cmd_allow),  32'd1);
        check("d_rst_active", 32'(ref_active), 32'd0);
        refresh_needed = 1'b0;
        bank_open      = 16'h0000;
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
        tick();
        c = cyc;
        refresh_needed = 1'b1;
        expect_pulse(K_REF, c + 2, "d_fresh_refresh");
        tick();
        tick();
        tick();
        handshake("d");
        repeat (2) tick();

        // E: request while traffic is pending.
        tick();
        c = cyc;
        refresh_needed = 1'b1;
        cmd_req        = 1'b1;
`ifdef REFRESH_POSTPONE_EN
        // DEFER from c+1 for PMAX cycles, DRAIN at c+1+PMAX, REF one later.
        expect_pulse(K_REF, c + 2 + PMAX, "e_refresh");
        tick();                                   // DEFER entry
        check("e_defer_allow",  32'(cmd_allow),  32'd1);
        check("e_defer_active", 32'(ref_active), 32'd1);
        repeat (PMAX - 1) tick();                 // last DEFER cycle
        check("e_defer_last_allow", 32'(cmd_allow), 32'd1);
        tick();                                   // DRAIN
        check("e_drain_allow", 32'(cmd_allow), 32'd0);
        tick();                                   // REFRESH
        tick();                                   // WAIT_DONE
`else
        // Without deferral pending traffic does not delay the refresh.
        expect_pulse(K_REF, c + 2, "e_refresh");
        tick();                                   // DRAIN
        check("e_drain_allow", 32'(cmd_allow), 32'd0);
        tick();                                   // REFRESH
        tick();                                   // WAIT_DONE
`endif
        cmd_req = 1'b0;
        handshake("e");
        repeat (4) tick();

        check("all_pulses_seen", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
